counter_4bit_sched: RTL and testbench
=====================================

# counter_4bit_sched

Two-requester interval scheduler that shares one 4-bit loadable up-counter (synchronous load, free-running +1 otherwise). It arbitrates round-robin between two clients. It programs the granted client's interval length into the counter and watches the count for terminal value 4'hF. It then returns a one-cycle completion pulse to that client. It sits between the clients and the counter instance, driving the counter's `load`/`load_data` and reading back `count`.

## Interface
Parameters:
- none (requester count fixed at 2, counter width fixed at 4)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req  input  2  request per client; bit i held high until done[i] observed
- len0  input  4  client 0 interval length, sampled at grant
- len1  input  4  client 1 interval length, sampled at grant
- count  input  4  current value from the shared counter
- load  output  1  counter load strobe (registered)
- load_data  output  4  value loaded into counter when load=1 (registered)
- grant  output  2  one-hot owner of the counter; 2'b00 when idle
- done  output  2  one-cycle completion pulse to the owner
- busy  output  1  high in every state except IDLE

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: when req != 0, select the winner, latch its len, set grant to the winner, go to LOAD. Otherwise stay in IDLE.
- Arbitration: round-robin pointer `last` holds the last-served client. If both req bits are high, the client != last wins. A single requester wins regardless of last.
- LOAD: load=1, load_data = 4'hF - len_latched (4-bit, no wrap possible). Go to RUN.
- RUN: load=0. When count == 4'hF, go to DONE; else stay.
- DONE: done[winner]=1 for exactly this cycle, grant still set. At the edge leaving DONE: grant<=0, last<=winner, go to IDLE.
- len=0: loads 4'hF, so RUN lasts 1 cycle.
- len=15: loads 4'h0, so RUN lasts 16 cycles.
- The counter free-runs while IDLE; its value is ignored outside RUN.
- req is sampled only in IDLE. Changes to req or len during LOAD/RUN/DONE are ignored.
- Requester contract: deassert req in the cycle after the done pulse. A req still high in the following IDLE is treated as a new request.
- Withdrawal of req by the current owner before done is a protocol violation. The interval completes anyway.

## Timing
- Reset (async assert, sync-released by the system) gives:
  - state=IDLE, last=1 (client 0 favored first)
  - load=0, load_data=4'h0, grant=2'b00, done=2'b00, busy=0
- Reset mid-operation: all outputs go to reset values immediately. No done is issued for the aborted interval.
- All outputs are registered; there is no combinational path from req/count to outputs.
- If req is first seen high in IDLE cycle T:
  - grant, load and busy are high in T+1 (LOAD).
  - count = 4'hF - len in T+2.
  - RUN covers T+2 .. T+2+len.
  - done pulses in T+3+len.
  - IDLE resumes in T+4+len.
- Request-to-done latency = len+3 cycles.
- Back-to-back: the second client's grant rises at the earliest 2 cycles after the first client's done.
- count is compared in the same cycle it is presented (registered-input compare into the next-state logic).

## Test plan
- Reset, then req=2'b01, len0=4'd3 → grant=01 and load=1 with load_data=4'hC one cycle later; count 12,13,14,15 in RUN; done=01 exactly 6 cycles after req sampled; busy low afterwards.
- Both req high from reset, len0=2, len1=5 → client 0 served first (done 5 cycles after sample), then client 1 (grant=10, load_data=4'hA, done 8 cycles after its IDLE sample); third round with both high favors client 0 again.
- len0=0 → load_data=4'hF, single RUN cycle, done 3 cycles after sample. len1=15 → load_data=4'h0, 16 RUN cycles, done 18 cycles after sample.
- Change len0 and toggle req[1] during RUN → no effect on the current interval; done timing unchanged; the new req[1] is sampled only in the next IDLE.
- Assert reset_n=0 in the middle of RUN → grant, load, done and busy drop asynchronously with no done pulse; after release, a fresh req=01, len0=1 completes in 4 cycles.
- Requester keeps req[0] high for one extra cycle after done → it is treated as a new request: a second grant to client 0 with a fresh load.

Source files
------------

// File: rtl/counter_4bit_sched.sv
// counter_4bit_sched
// Two-client interval scheduler in front of a shared 4-bit loadable up-counter.
// A granted client's interval length is turned into a counter preload of
// (4'hF - len). The interval ends when the counter presents 4'hF. The owner
// then gets a single-cycle done pulse. Every output is driven from a flop.

module counter_4bit_sched (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic [3:0] len0,
    input  logic [3:0] len1,
    input  logic [3:0] count,
    output logic       load,
    output logic [3:0] load_data,
    output logic [1:0] grant,
    output logic [1:0] done,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [3:0] TERM = 4'hF;

    state_e     state_q, state_d;
    logic       last_q, last_d;       // last client served (round-robin pointer)
    logic       winner_q, winner_d;   // client owning the current interval
    logic       load_q, load_d;
    logic [3:0] load_data_q, load_data_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] done_q, done_d;
    logic       busy_q, busy_d;

    // Arbitration outcome for the current req. Only consumed in IDLE.
    // With both bits set, the client that was not served last wins.
    // With a single bit set, that client wins: for req=01 this gives 0, and
    // for req=10 it gives 1, so ~req[0] covers both single-requester cases.
    logic       arb_win;
    logic [3:0] arb_len;

    // Round-robin pick plus the interval length of the chosen client.
    always_comb begin
        arb_win = ~req[0];
        if (req == 2'b11) begin
            arb_win = ~last_q;
        end
        arb_len = arb_win ? len1 : len0;
    end

    // Next-state logic. Output next values are derived from the next state,
    // so every output lines up with the state it belongs to.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        winner_d    = winner_q;
        grant_d     = grant_q;
        load_data_d = load_data_q;

        case (state_q)
            S_IDLE: begin
                // req is only looked at here. Lengths are latched at grant
                // time through load_data, so later len changes cannot
                // disturb the interval in flight.
                if (req != 2'b00) begin
                    winner_d    = arb_win;
                    grant_d     = arb_win ? 2'b10 : 2'b01;
                    load_data_d = TERM - arb_len;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                // The counter takes load_data on the edge leaving this state.
                state_d = S_RUN;
            end
            S_RUN: begin
                // An owner that drops req early still gets its interval
                // completed. Only the counter reaching TERM ends RUN.
                if (count == TERM) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                grant_d = 2'b00;
                last_d  = winner_q;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
        endcase

        load_d = (state_d == S_LOAD);
        busy_d = (state_d != S_IDLE);
        // In DONE the grant register still holds the owner's one-hot code.
        done_d = (state_d == S_DONE) ? grant_d : 2'b00;
    end

    // State and registered outputs. Reset favors client 0 first (last=1).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            winner_q    <= 1'b0;
            load_q      <= 1'b0;
            load_data_q <= 4'h0;
            grant_q     <= 2'b00;
            done_q      <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            winner_q    <= winner_d;
            load_q      <= load_d;
            load_data_q <= load_data_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign load      = load_q;
    assign load_data = load_data_q;
    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_counter_4bit_sched.sv
// Testbench for counter_4bit_sched. Directed steps followed by randomized
// rounds. Expected outputs come from a transaction-level timeline:
//   - a request sampled in IDLE cycle T gives grant/load in T+1;
//   - the count runs from F-len upward over T+2..T+2+len;
//   - done pulses in T+3+len;
//   - the block is back in IDLE at T+4+len.
// The round-robin choice is modelled from the arbitration rule.

module tb_counter_4bit_sched;

    logic       clk;
    logic       reset_n;
    logic [1:0] req;
    logic [3:0] len0, len1;
    logic [3:0] count;
    logic       load;
    logic [3:0] load_data;
    logic [1:0] grant;
    logic [1:0] done;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int model_last = 1;

    counter_4bit_sched dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .len0      (len0),
        .len1      (len1),
        .count     (count),
        .load      (load),
        .load_data (load_data),
        .grant     (grant),
        .done      (done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared counter: synchronous load, free-running +1 otherwise.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)  count <= 4'h0;
        else if (load) count <= load_data;
        else           count <= count + 4'h1;
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle. Sampling and driving happen 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [1:0] r, input int last);
        if (r == 2'b11) return (last == 0) ? 1 : 0;
        if (r[0])       return 0;
        return 1;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ".grant"}, {2'b00, grant}, 4'h0);
        check({tag, ".load"},  {3'b000, load}, 4'h0);
        check({tag, ".done"},  {2'b00, done},  4'h0);
        check({tag, ".busy"},  {3'b000, busy}, 4'h0);
    endtask

    // One full interval, called from an IDLE cycle in which req has just
    // been set up. It returns in the following IDLE cycle.
    //   keep    : leave req[w] high after done (a new request).
    //   perturb : change len0 and toggle req[1] in the first RUN cycle.
    task automatic txn(input int w, input logic [3:0] len, input bit keep, input bit perturb);
        logic [1:0] oh;
        logic [3:0] exp_cnt;
        int n;
        oh = (w == 0) ? 2'b01 : 2'b10;
        n  = int'(len);
        for (int k = 1; k <= n + 4; k++) begin
            tick();
            check("grant", {2'b00, grant}, (k <= n + 3) ? {2'b00, oh} : 4'h0);
            check("load",  {3'b000, load}, (k == 1) ? 4'h1 : 4'h0);
            check("done",  {2'b00, done},  (k == n + 3) ? {2'b00, oh} : 4'h0);
            check("busy",  {3'b000, busy}, (k <= n + 3) ? 4'h1 : 4'h0);
            if (k == 1) check("load_data", load_data, 4'hF - len);
            if (k >= 2 && k <= n + 2) begin
                exp_cnt = 4'hF - len + 4'(k - 2);
                check("count", count, exp_cnt);
            end
            if (perturb && k == 2) begin
                len0   = 4'($urandom);
                req[1] = ~req[1];
            end
            if (k == n + 3 && !keep) req[w] = 1'b0;
        end
        model_last = w;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = 2'b00;
        #3;
        tick();
        reset_n    = 1'b1;
        model_last = 1;
    endtask

    initial begin
        logic [1:0] r;
        int w;
        reset_n = 1'b0;
        req     = 2'b00;
        len0    = 4'h0;
        len1    = 4'h0;

        // Reset values.
        #12;
        check_idle("rst");
        check("rst.load_data", load_data, 4'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single client 0 with len 3.
        req = 2'b01; len0 = 4'd3;
        txn(0, 4'd3, 1'b0, 1'b0);
        check_idle("post_single");

        // Both clients from reset: client 0, then 1, then 0 again.
        do_reset();
        req = 2'b11; len0 = 4'd2; len1 = 4'd5;
        txn(pick(req, model_last), 4'd2, 1'b0, 1'b0);
        check("rr.second_is_1", 4'(pick(req, model_last)), 4'h1);
        txn(1, 4'd5, 1'b0, 1'b0);
        req = 2'b11;
        check("rr.third_is_0", 4'(pick(req, model_last)), 4'h0);
        txn(0, 4'd2, 1'b0, 1'b0);
        txn(1, 4'd5, 1'b0, 1'b0);

        // Length boundaries.
        req = 2'b01; len0 = 4'd0;
        txn(0, 4'd0, 1'b0, 1'b0);
        req = 2'b10; len1 = 4'd15;
        txn(1, 4'd15, 1'b0, 1'b0);

        // Changes during RUN are ignored. req[1] is raised mid-run and
        // served in the next IDLE.
        req = 2'b01; len0 = 4'd4; len1 = 4'd1;
        txn(0, 4'd4, 1'b0, 1'b1);
        check("perturb.req1", {3'b000, req[1]}, 4'h1);
        txn(1, 4'd1, 1'b0, 1'b0);

        // Reset in the middle of RUN.
        req = 2'b01; len0 = 4'd10;
        tick(); tick(); tick(); tick();
        #2;
        reset_n = 1'b0;
        req     = 2'b00;
        #1;
        check_idle("midrst");
        check("midrst.load_data", load_data, 4'h0);
        tick();
        check_idle("midrst_hold");
        tick();
        reset_n    = 1'b1;
        model_last = 1;
        req = 2'b01; len0 = 4'd1;
        txn(0, 4'd1, 1'b0, 1'b0);

        // req held past done: a new request gets a fresh load.
        req = 2'b01; len0 = 4'd2;
        txn(0, 4'd2, 1'b1, 1'b0);
        txn(0, 4'd2, 1'b0, 1'b0);

        // Randomized rounds. Waiting clients keep their req bit set.
        for (int i = 0; i < 40; i++) begin
            r    = 2'($urandom_range(0, 3));
            req  = req | r;
            len0 = 4'($urandom);
            len1 = 4'($urandom);
            if (req == 2'b00) begin
                tick();
                check_idle("rand_idle");
            end else begin
                w = pick(req, model_last);
                txn(w, (w == 0) ? len0 : len1, 1'b0, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
